// File: rtl/stream_mux.sv
// stream_mux: M-to-1 stream arbiter (fixed priority or round-robin) feeding a registered output beat.
module stream_mux #(
  parameter int N = 32,
  parameter int M = 4,
  localparam int S = $clog2(M)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [M-1:0]   in_valid,
  input  logic [N*M-1:0] in_data,
  output logic [M-1:0]   in_ready,
  output logic           out_valid,
  output logic [N-1:0]   out_data,
  output logic [S-1:0]   out_sel,
  input  logic           out_ready
);
  logic [S-1:0] ptr, gidx, cand;
  logic load, any;
  assign load = !out_valid | out_ready;
  assign any = |in_valid;
  // Scan candidates in reverse search order so the earliest valid one is written last.
  always_comb begin
    gidx = '0;
    cand = '0;
    for (int i = M - 1; i >= 0; i--) begin
      cand = S'(mode ? (int'(ptr) + 1 + i) % M : i);
      if (in_valid[cand]) gidx = cand;
    end
  end
  always_comb in_ready = (!rst && load && any) ? M'(1) << gidx : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
      ptr <= S'(M - 1);
    end else if (load) begin
      out_valid <= any;
      if (any) begin
        out_data <= in_data[int'(gidx) * N +: N];
        out_sel <= gidx;
        ptr <= gidx;
      end
    end
  end
endmodule

// File: tb/tb_stream_mux.sv
// tb_stream_mux: directed and model-checked random stimulus for stream_mux (N=8, M=4).
module tb_stream_mux;
  localparam int N = 8, M = 4;
  logic clk = 1'b0, rst = 1'b1, mode = 1'b0, out_ready = 1'b0;
  logic [M-1:0] in_valid = '0, in_ready, g;
  logic [N*M-1:0] in_data;
  logic out_valid;
  logic [N-1:0] out_data, mdata;
  logic [1:0] out_sel, msel;
  logic [7:0] d [M];
  logic [5:0] cnt [M];
  logic mv;
  int mptr;
  int passed = 0, total = 0;
  int wseq [3] = '{0, 3, 0};
  always #5 clk = ~clk;
  assign in_data = {d[3], d[2], d[1], d[0]};
  stream_mux #(.N(N), .M(M)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [3:0] ref_grant(input logic md, input logic [3:0] v, input int p);
    for (int i = 1; i <= 4; i++) begin
      int k = md ? (p + i) % 4 : i - 1;
      if (v[k]) return 4'(1 << k);
    end
    return '0;
  endfunction
  initial begin
    d[0] = 8'hA5; d[1] = 8'hB1; d[2] = 8'hC2; d[3] = 8'hD3;
    in_valid = 4'b1111; out_ready = 1'b1;
    #1 chk("rst_in_ready", in_ready, 0);
    tick;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sel", out_sel, 0);
    rst = 1'b0; mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1 chk("rr_ready", in_ready, 4'b0001 << (i % 4));
      tick;
      chk("rr_sel", out_sel, i % 4);
      chk("rr_valid", out_valid, 1);
      chk("rr_data", out_data, d[i % 4]);
    end
    in_valid = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("wrap_sel", out_sel, wseq[i]);
    end
    mode = 1'b0; in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1 chk("fix_ready", in_ready, 4'b0010);
      tick;
      chk("fix_sel", out_sel, 1);
      chk("fix_data", out_data, 8'hB1);
    end
    in_valid = 4'b0001;
    tick;
    chk("bp_load", out_data, 8'hA5);
    out_ready = 1'b0; d[0] = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", in_ready, 0);
      tick;
      chk("bp_hold", out_data, 8'hA5);
      chk("bp_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    #1 chk("bp_release", in_ready, 4'b0001);
    tick;
    chk("bp_next", out_data, 8'h5A);
    d[0] = 8'hA5; in_valid = 4'b0000;
    #1 chk("drain_ready", in_ready, 0);
    tick;
    chk("drain_valid", out_valid, 0);
    chk("drain_data", out_data, 8'h5A);
    chk("drain_sel", out_sel, 0);
    mode = 1'b1; in_valid = 4'b0100;
    #1 chk("stall_ready", in_ready, 4'b0100);
    tick;
    chk("stall_sel", out_sel, 2);
    chk("stall_data", out_data, 8'hC2);
    out_ready = 1'b0; rst = 1'b1;
    #1 chk("rst2_ready", in_ready, 0);
    tick;
    chk("rst2_valid", out_valid, 0);
    chk("rst2_data", out_data, 0);
    rst = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
    #1 chk("rst2_ptr", in_ready, 4'b0001);
    tick;
    chk("rst2_sel", out_sel, 0);
    chk("rst2_first", out_data, 8'hA5);
    #1 chk("mode_rr", in_ready, 4'b0010);
    mode = 1'b0;
    #1 chk("mode_fix", in_ready, 4'b0001);
    mode = 1'b1;
    #1 chk("mode_back", in_ready, 4'b0010);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    mv = 1'b0; mptr = 3; mdata = '0; msel = '0;
    for (int k = 0; k < M; k++) cnt[k] = '0;
    for (int c = 0; c < 300; c++) begin
      in_valid = 4'($urandom);
      out_ready = 1'($urandom);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      for (int k = 0; k < M; k++) d[k] = {2'(k), cnt[k]};
      #1;
      g = (!mv || out_ready) ? ref_grant(mode, in_valid, mptr) : '0;
      chk("rnd_ready", in_ready, g);
      chk("rnd_valid", out_valid, mv);
      if (mv) begin
        chk("rnd_data", out_data, mdata);
        chk("rnd_sel", out_sel, msel);
      end
      if (!mv || out_ready) mv = |in_valid;
      for (int k = 0; k < M; k++)
        if (g[k]) begin
          mptr = k;
          mdata = d[k];
          msel = 2'(k);
          cnt[k]++;
        end
      tick;
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 SHALL have parameter N, default 32: data width per channel in bits.
REQ-002 SHALL have parameter M, default 4: channel count, legal range 2..16.
REQ-003 SHALL have localparam S = $clog2(M): select/index width.
REQ-004 SHALL run on one clock and one reset; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 mode  input  1  0 = fixed priority, lowest index wins; 1 = round-robin.
REQ-008 in_valid  input  M  bit k = channel k offers a beat.
REQ-009 in_data  input  N*M  channel k occupies bits [k*N +: N].
REQ-010 in_ready  output  M  bit k = channel k beat accepted this cycle.
REQ-011 out_valid  output  1  registered output beat present.
REQ-012 out_data  output  N  registered output beat.
REQ-013 out_sel  output  S  source channel index of the current out_data.
REQ-014 out_ready  input  1  downstream accepts the output beat.

Function
REQ-015 SHALL define load = !out_valid | out_ready; a new beat may enter only when load=1.
REQ-016 SHALL compute grant combinationally each cycle; at most one in_ready bit high; in_ready[k] = load & grant[k] & in_valid[k].
REQ-017 mode=0: grant = lowest index k with in_valid[k]=1.
REQ-018 mode=1: grant = first k with in_valid[k]=1, searching ptr+1, ptr+2, ... modulo M and wrapping; ptr itself is searched last.
REQ-019 On a transfer (any in_ready bit high): out_data <= granted channel data, out_sel <= k, out_valid <= 1, ptr <= k; these updates occur in both modes.
REQ-020 If load=1 and no in_valid bit is high: out_valid <= 0; out_data and out_sel hold.
REQ-021 If load=0 (out_valid=1, out_ready=0): out_valid, out_data and out_sel hold; all in_ready bits are 0.
REQ-022 Latency: a beat accepted in cycle t appears on out_data at cycle t+1.
REQ-023 Throughput: one beat per cycle while out_ready=1 and any in_valid bit is high; no bubble on back-to-back transfers.
REQ-024 An output pop and an input load in the same cycle SHALL both occur; the register is replaced, not emptied.
REQ-025 A mode change takes effect in the same cycle's arbitration; ptr is not reset by a mode change.
REQ-026 in_ready SHALL depend on in_valid, out_ready, mode and state only; it never depends on in_data.
REQ-027 Round-robin fairness: with all M channels continuously valid, each channel is granted exactly once in every M consecutive transfers.

Reset
REQ-028 In a cycle where rst=1: out_valid <= 0, out_data <= 0, out_sel <= 0, ptr <= M-1, and all in_ready bits = 0.
REQ-029 Reset mid-transfer SHALL discard the held beat; the first grant after reset in mode=1 goes to the lowest valid index at or above 0.

Verification
REQ-030 Reset, then M=4, mode=1, in_valid=4'b1111, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3; out_valid=1 from cycle 2 of the run onward.
REQ-031 mode=0, in_valid=4'b1010, out_ready=1 -> in_ready=4'b0010 every cycle and out_sel=1 continuously; channel 3 starves.
REQ-032 Backpressure: out_valid=1 holding data 0xA5, out_ready=0 for 3 cycles, in_valid=4'b0001 -> in_ready=0, out_data stays 0xA5; in the first out_ready=1 cycle in_ready[0]=1.
REQ-033 Wrap: mode=1, last grant ptr=3, in_valid=4'b1001 -> grant 0, then 3, then 0.
REQ-034 Drain: out_valid=1, out_ready=1, in_valid=0 -> out_valid=0 next cycle with out_data held; apply rst during a stalled beat -> out_valid=0 next cycle and ptr=3.
REQ-035 Random stimulus with random out_ready: compare against a reference model; no beat is lost or duplicated, and out_data ordering per channel is preserved.
